// File: rtl/uc_multiciclo.sv
// -----------------------------------------------------------------------------
// uc_multiciclo -- multicycle control unit
//
// Owns the program counter and fetches from a synchronous program memory. Each
// instruction is sequenced through FETCH -> DECODE -> EXEC, which takes three
// cycles. HALT parks the unit in HALTED until reset. CALL/RET use an internal
// LIFO return-address stack. Stack overflow and underflow are reported through
// sticky flags.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   pc       instruction address to program memory
//   instr    program memory read data (valid one cycle after pc)
//   z        zero flag from the datapath
//   ir       instruction register (datapath takes its fields from here)
//   we3      register file write enable        (EXEC only)
//   s_inm    1: immediate, 0: ALU result       (EXEC only)
//   op       ALU operation                     (EXEC only)
//   halted   set once HALT has executed
//   stk_ovf  sticky: CALL attempted with stack full
//   stk_unf  sticky: RET attempted with stack empty
//   illegal  one-cycle pulse in EXEC for an undefined opcode
// -----------------------------------------------------------------------------
module uc_multiciclo #(
    parameter int PCW   = 10,
    parameter int IW    = 16,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    output logic [PCW-1:0] pc,
    input  logic [IW-1:0]  instr,
    input  logic           z,
    output logic [IW-1:0]  ir,
    output logic           we3,
    output logic           s_inm,
    output logic [2:0]     op,
    output logic           halted,
    output logic           stk_ovf,
    output logic           stk_unf,
    output logic           illegal
);

    // sp counts 0..DEPTH, so it needs one more code than the stack index.
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [5:0] OP_JMP  = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_CALL = 6'b010011;
    localparam logic [5:0] OP_RET  = 6'b010100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        HALTED
    } state_t;

    state_t         state;
    logic [SPW-1:0] sp;
    logic [PCW-1:0] stack [DEPTH];

    logic [5:0]     opc;
    logic [PCW-1:0] target;
    logic [PCW-1:0] pc_inc;
    logic [SPW-1:0] sp_dec;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic           stk_full;
    logic           stk_empty;
    logic           do_push;

    assign opc       = ir[IW-1 -: 6];
    assign target    = ir[PCW-1:0];
    assign pc_inc    = pc + PCW'(1);          // wraps modulo 2^PCW
    assign sp_dec    = sp - SPW'(1);
    assign wr_idx    = sp[AW-1:0];
    assign rd_idx    = sp_dec[AW-1:0];
    assign stk_full  = (sp == SPW'(DEPTH));
    assign stk_empty = (sp == '0);
    assign do_push   = (state == EXEC) && (opc == OP_CALL) && !stk_full;

    // -------------------------------------------------------------------------
    // Return-address stack storage.
    // NOTE: storage has no reset; sp alone defines which entries are live.
    // Gating with reset keeps a reset that lands on the EXEC edge from
    // leaving a half-done CALL behind.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            stack[wr_idx] <= pc_inc;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer, program counter, instruction register, stack pointer, flags.
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            sp      <= '0;
            halted  <= 1'b0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    ir    <= instr;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    // ALU, load-immediate and undefined opcodes all fall through.
                    pc    <= pc_inc;
                    case (opc)
                        OP_JMP: pc <= target;
                        OP_JZ:  pc <= z ? target : pc_inc;
                        OP_JNZ: pc <= z ? pc_inc : target;
                        OP_CALL: begin
                            if (stk_full) begin
                                stk_ovf <= 1'b1;
                            end else begin
                                sp <= sp + SPW'(1);
                                pc <= target;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                stk_unf <= 1'b1;
                            end else begin
                                sp <= sp_dec;
                                pc <= stack[rd_idx];
                            end
                        end
                        OP_HALT: begin
                            pc     <= pc;
                            halted <= 1'b1;
                            state  <= HALTED;
                        end
                        default: ;
                    endcase
                end
                HALTED: ;
                default: state <= FETCH;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath controls are decoded straight from ir during EXEC. Because
    // state resets asynchronously, a reset in EXEC drops we3 without a clock.
    // NOTE: every output gets a default first so no latch is inferred.
    // -------------------------------------------------------------------------
    always_comb begin
        we3     = 1'b0;
        s_inm   = 1'b0;
        op      = 3'b000;
        illegal = 1'b0;
        if (state == EXEC) begin
            case (opc)
                OP_JMP, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_HALT: ;
                default: begin
                    if (opc[5:3] == 3'b000) begin
                        we3 = 1'b1;
                        op  = opc[2:0];
                    end else if (opc[5:3] == 3'b001) begin
                        we3   = 1'b1;
                        s_inm = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_uc_multiciclo -- directed self-checking bench for uc_multiciclo
//
// A synchronous program memory model feeds the DUT. Each scenario loads a
// small program, releases reset right after a rising edge (that period is
// cycle 1), and samples outputs on falling edges. Each instruction spans three
// cycles, so instruction k (0-based) executes in cycle 3k+3.
// -----------------------------------------------------------------------------
module tb_uc_multiciclo;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pc;
    logic [15:0] instr;
    logic        z;
    logic [15:0] ir;
    logic        we3;
    logic        s_inm;
    logic [2:0]  op;
    logic        halted;
    logic        stk_ovf;
    logic        stk_unf;
    logic        illegal;

    logic [15:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    uc_multiciclo #(.PCW(10), .IW(16), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .pc      (pc),
        .instr   (instr),
        .z       (z),
        .ir      (ir),
        .we3     (we3),
        .s_inm   (s_inm),
        .op      (op),
        .halted  (halted),
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data valid one cycle after the address.
    always @(posedge clk) instr <= mem[pc];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [5:0] o, input logic [9:0] t);
        return {o, t};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = {6'b111111, 10'h000};
    endtask

    // Leaves the bench at the falling edge of cycle 1 (FETCH of pc=0).
    task automatic restart();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic next_instr();
        repeat (3) @(negedge clk);
    endtask

    // Runs one instruction, checking that no register write occurs.
    task automatic instr_no_write(input string tag);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s_we3_c%0d", tag, c), 32'(we3), 32'(0));
            @(negedge clk);
        end
    endtask

    int          pc_e;
    int          we3_e;
    logic [9:0]  pc_tab [13];

    initial begin
        reset = 1'b0;
        z     = 1'b0;
        clear_mem();

        // ---------------- reset state ----------------
        #12;
        check("rst_pc",      32'(pc),      32'(0));
        check("rst_ir",      32'(ir),      32'(0));
        check("rst_we3",     32'(we3),     32'(0));
        check("rst_s_inm",   32'(s_inm),   32'(0));
        check("rst_op",      32'(op),      32'(0));
        check("rst_halted",  32'(halted),  32'(0));
        check("rst_ovf",     32'(stk_ovf), 32'(0));
        check("rst_unf",     32'(stk_unf), 32'(0));
        check("rst_illegal", 32'(illegal), 32'(0));

        // ---------------- load-imm, ALU op=010, HALT ----------------
        mem[0] = ins(6'b001000, 10'h0a5);
        mem[1] = ins(6'b000010, 10'h123);
        mem[2] = ins(6'b111111, 10'h000);
        restart();
        for (int c = 1; c <= 12; c++) begin
            pc_e  = (c <= 3) ? 0 : (c <= 6) ? 1 : 2;
            we3_e = (c == 3 || c == 6) ? 1 : 0;
            check($sformatf("seq_pc_c%0d", c),    32'(pc),    32'(pc_e));
            check($sformatf("seq_we3_c%0d", c),   32'(we3),   32'(we3_e));
            check($sformatf("seq_s_inm_c%0d", c), 32'(s_inm), 32'((c == 3) ? 1 : 0));
            check($sformatf("seq_op_c%0d", c),    32'(op),    32'((c == 6) ? 2 : 0));
            check($sformatf("seq_ill_c%0d", c),   32'(illegal), 32'(0));
            if (c >= 10) check($sformatf("seq_halted_c%0d", c), 32'(halted), 32'(1));
            if (c <= 8)  check($sformatf("seq_halted_c%0d", c), 32'(halted), 32'(0));
            if (c == 3)  check("seq_ir_li", 32'(ir), 32'(16'h20a5));
            if (c < 12) @(negedge clk);
        end
        // z toggling must not disturb a halted unit.
        z = 1'b1;
        repeat (4) @(negedge clk);
        check("halt_pc_hold", 32'(pc),  32'(2));
        check("halt_ir_hold", 32'(ir),  32'(16'hfc00));
        check("halt_we3",     32'(we3), 32'(0));

        // ---------------- JZ taken / not taken, JNZ taken ----------------
        clear_mem();
        mem[10'h000] = ins(6'b010001, 10'h020);   // JZ 0x020, z=1
        mem[10'h020] = ins(6'b010001, 10'h020);   // JZ 0x020, z=0
        mem[10'h021] = ins(6'b010010, 10'h040);   // JNZ 0x040, z=0
        z = 1'b1;
        restart();
        instr_no_write("jz1");
        check("jz_taken_pc", 32'(pc), 32'(10'h020));
        z = 1'b0;
        instr_no_write("jz0");
        check("jz_fall_pc", 32'(pc), 32'(10'h021));
        instr_no_write("jnz0");
        check("jnz_taken_pc", 32'(pc), 32'(10'h040));

        // ---------------- nested CALLs, overflow, RETs, underflow ----------------
        clear_mem();
        mem[10'h000] = ins(6'b010000, 10'h010);   // JMP 0x010
        mem[10'h010] = ins(6'b010011, 10'h100);   // CALL -> push 0x011
        mem[10'h100] = ins(6'b010011, 10'h110);   // CALL -> push 0x101
        mem[10'h110] = ins(6'b010011, 10'h120);   // CALL -> push 0x111
        mem[10'h120] = ins(6'b010011, 10'h130);   // CALL -> push 0x121 (full)
        mem[10'h130] = ins(6'b010011, 10'h200);   // CALL overflow -> 0x131
        mem[10'h131] = ins(6'b010100, 10'h000);   // RET -> 0x121
        mem[10'h121] = ins(6'b010100, 10'h000);   // RET -> 0x111
        mem[10'h111] = ins(6'b010100, 10'h000);   // RET -> 0x101
        mem[10'h101] = ins(6'b010100, 10'h000);   // RET -> 0x011
        mem[10'h011] = ins(6'b010100, 10'h000);   // RET empty -> 0x012
        mem[10'h012] = ins(6'b010011, 10'h300);   // CALL -> push 0x013
        mem[10'h300] = ins(6'b010100, 10'h000);   // RET -> 0x013
        pc_tab = '{10'h010, 10'h100, 10'h110, 10'h120, 10'h130, 10'h131,
                   10'h121, 10'h111, 10'h101, 10'h011, 10'h012, 10'h300, 10'h013};
        restart();
        for (int k = 0; k < 13; k++) begin
            instr_no_write($sformatf("stk%0d", k));
            check($sformatf("stk_pc_%0d", k),  32'(pc),      32'(pc_tab[k]));
            check($sformatf("stk_ovf_%0d", k), 32'(stk_ovf), 32'((k >= 5) ? 1 : 0));
            check($sformatf("stk_unf_%0d", k), 32'(stk_unf), 32'((k >= 10) ? 1 : 0));
        end

        // ---------------- undefined opcode ----------------
        clear_mem();
        mem[0] = ins(6'b011111, 10'h000);
        restart();
        check("ill_c1", 32'(illegal), 32'(0));
        @(negedge clk);
        check("ill_c2", 32'(illegal), 32'(0));
        @(negedge clk);
        check("ill_c3", 32'(illegal), 32'(1));
        check("ill_we3", 32'(we3), 32'(0));
        @(negedge clk);
        check("ill_c4", 32'(illegal), 32'(0));
        check("ill_pc", 32'(pc), 32'(1));

        // ---------------- JMP at 0x3FF ----------------
        clear_mem();
        mem[10'h000] = ins(6'b010000, 10'h3ff);
        mem[10'h3ff] = ins(6'b010000, 10'h155);
        restart();
        next_instr();
        check("jmp_to_3ff", 32'(pc), 32'(10'h3ff));
        next_instr();
        check("jmp_at_3ff", 32'(pc), 32'(10'h155));

        // ---------------- plain instruction at 0x3FF wraps ----------------
        mem[10'h3ff] = ins(6'b001000, 10'h000);
        restart();
        next_instr();
        next_instr();
        check("wrap_pc", 32'(pc), 32'(0));

        // ---------------- CALL at 0x3FF pushes 0 ----------------
        mem[10'h3ff] = ins(6'b010011, 10'h050);
        mem[10'h050] = ins(6'b010100, 10'h000);
        restart();
        next_instr();
        next_instr();
        check("call_3ff_pc", 32'(pc), 32'(10'h050));
        next_instr();
        check("ret_wrap_pc", 32'(pc), 32'(0));
        check("ret_wrap_unf", 32'(stk_unf), 32'(0));

        // ---------------- async reset in EXEC of an ALU op ----------------
        clear_mem();
        mem[10'h000] = ins(6'b010011, 10'h008);   // CALL leaves sp=1
        mem[10'h008] = ins(6'b000010, 10'h000);   // ALU op=010
        restart();
        next_instr();
        check("ar_call_pc", 32'(pc), 32'(10'h008));
        @(negedge clk);
        @(negedge clk);
        check("ar_we3_before", 32'(we3), 32'(1));
        #2 reset = 1'b0;
        #1;
        check("ar_we3_async", 32'(we3), 32'(0));
        check("ar_pc",        32'(pc),  32'(0));
        check("ar_ir",        32'(ir),  32'(0));
        check("ar_ovf",       32'(stk_ovf), 32'(0));
        check("ar_unf",       32'(stk_unf), 32'(0));
        check("ar_halted",    32'(halted),  32'(0));
        // A RET right after release must see an empty stack.
        mem[10'h000] = ins(6'b010100, 10'h000);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("ar_fetch_pc", 32'(pc), 32'(0));
        next_instr();
        check("ar_ret_pc",  32'(pc),      32'(1));
        check("ar_ret_unf", 32'(stk_unf), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
